mystic_uart_mem_packer: RTL and testbench

Downstream stage of the UART boot-loader receive path. It consumes the byte-wide write stream produced by `mystic_main_mem_rx` (`uart_mem_dout`, `uart_mem_addr`, `uart_mem_we`, `disable_core_n`) and packs the bytes into 64-bit, byte-strobed word writes for the RV64 main memory. It also flushes any partial word when loading ends and signals completion so the core can be released.

---
 rtl/mystic_uart_mem_packer.sv | 133 +++++++++++++
 tb/tb_mystic_uart_mem_packer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mystic_uart_mem_packer.sv
// Packs the UART boot-loader byte write stream into byte-strobed 64-bit word writes.
// Optional running byte checksum output: define MYSTIC_PACKER_CHECKSUM_EN.
module mystic_uart_mem_packer #(
   parameter int ADDR_W      = 18,
   parameter int WORD_ADDR_W = ADDR_W - 3
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [7:0]             byte_i,
   input  logic [ADDR_W-1:0]      byte_addr_i,
   input  logic                   byte_we_i,
   input  logic                   disable_core_n_i,
   input  logic                   mem_ready_i,
   output logic                   mem_we_o,
   output logic [WORD_ADDR_W-1:0] mem_waddr_o,
   output logic [63:0]            mem_wdata_o,
   output logic [7:0]             mem_wstrb_o,
   output logic                   overflow_o,
   output logic                   done_o
`ifdef MYSTIC_PACKER_CHECKSUM_EN
   ,
   output logic [31:0]            checksum_o
`endif
);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

   state_t                 state, state_nx;
   logic [63:0]            acc_data;
   logic [7:0]             acc_strb;
   logic [WORD_ADDR_W-1:0] acc_waddr;

   logic [2:0]             lane;
   logic [WORD_ADDR_W-1:0] in_waddr;
   logic [7:0]             lane_bit;
   logic [63:0]            merged_data, fresh_data;
   logic [7:0]             merged_strb;

   logic out_free, word_chg, take, drop;
   logic flush_chg, flush_l7, merge, drain_flush, drain_done, start;

   assign lane     = byte_addr_i[2:0];
   assign in_waddr = byte_addr_i[ADDR_W-1:3];
   assign lane_bit = 8'b1 << lane;

   always_comb begin
      merged_data                     = acc_data;
      merged_data[{lane, 3'b000} +: 8] = byte_i;
      fresh_data                      = '0;
      fresh_data[{lane, 3'b000} +: 8]  = byte_i;
      merged_strb                     = acc_strb | lane_bit;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nx;
   end

   // The output register counts as free when its word is being accepted this edge.
   always_comb begin
      state_nx    = state;
      out_free    = !mem_we_o || mem_ready_i;
      word_chg    = (acc_strb != 8'd0) && (in_waddr != acc_waddr);
      take        = (state == LOAD) && byte_we_i;
      drop        = take && (word_chg || lane == 3'd7) && !out_free;
      flush_chg   = take && !drop && word_chg;
      flush_l7    = take && !drop && !word_chg && (lane == 3'd7);
      merge       = take && !drop && !word_chg && (lane != 3'd7);
      drain_flush = (state == DRAIN) && (acc_strb != 8'd0) && out_free;
      drain_done  = (state == DRAIN) && (acc_strb == 8'd0) && out_free;
      start       = (state == IDLE) && !disable_core_n_i;
      case (state)
         IDLE:    if (!disable_core_n_i) state_nx = LOAD;
         LOAD:    if (disable_core_n_i)  state_nx = DRAIN;
         DRAIN:   if (drain_done)        state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_data    <= '0;
         acc_strb    <= '0;
         acc_waddr   <= '0;
         mem_we_o    <= 1'b0;
         mem_waddr_o <= '0;
         mem_wdata_o <= '0;
         mem_wstrb_o <= '0;
         overflow_o  <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         done_o <= drain_done;
         if (mem_we_o && mem_ready_i) mem_we_o <= 1'b0;

         if (flush_chg || drain_flush) begin
            mem_we_o    <= 1'b1;
            mem_waddr_o <= acc_waddr;
            mem_wdata_o <= acc_data;
            mem_wstrb_o <= acc_strb;
         end else if (flush_l7) begin
            mem_we_o    <= 1'b1;
            mem_waddr_o <= in_waddr;
            mem_wdata_o <= merged_data;
            mem_wstrb_o <= merged_strb;
         end

         // Cleared data keeps unstrobed lanes of later words at zero.
         if (flush_chg) begin
            acc_data  <= fresh_data;
            acc_strb  <= lane_bit;
            acc_waddr <= in_waddr;
         end else if (flush_l7 || drain_flush) begin
            acc_data  <= '0;
            acc_strb  <= '0;
         end else if (merge) begin
            acc_data  <= merged_data;
            acc_strb  <= merged_strb;
            acc_waddr <= in_waddr;
         end

         if (start)     overflow_o <= 1'b0;
         else if (drop) overflow_o <= 1'b1;
      end
   end

`ifdef MYSTIC_PACKER_CHECKSUM_EN
   always_ff @(posedge clk_i) begin
      if (rst_i || start)     checksum_o <= '0;
      else if (take && !drop) checksum_o <= checksum_o + {24'd0, byte_i};
   end
`endif

endmodule

// File: tb/tb_mystic_uart_mem_packer.sv
// Bench for mystic_uart_mem_packer: directed cases plus random loads against a word-packing model.
module tb_mystic_uart_mem_packer;

   localparam int ADDR_W = 18;
   localparam int WA     = ADDR_W - 3;

   logic              clk = 1'b0;
   logic              rst_i;
   logic [7:0]        byte_i;
   logic [ADDR_W-1:0] byte_addr_i;
   logic              byte_we_i;
   logic              disable_core_n_i;
   logic              mem_ready_i;
   logic              mem_we_o;
   logic [WA-1:0]     mem_waddr_o;
   logic [63:0]       mem_wdata_o;
   logic [7:0]        mem_wstrb_o;
   logic              overflow_o;
   logic              done_o;
`ifdef MYSTIC_PACKER_CHECKSUM_EN
   logic [31:0]       checksum_o;
   logic [31:0]       m_sum;
`endif

   logic rnd_mode, rnd_ready, man_ready;
   assign mem_ready_i = rnd_mode ? rnd_ready : man_ready;

   always #5 clk = ~clk;

   mystic_uart_mem_packer #(.ADDR_W(ADDR_W)) dut (
      .clk_i(clk), .rst_i(rst_i), .byte_i(byte_i), .byte_addr_i(byte_addr_i),
      .byte_we_i(byte_we_i), .disable_core_n_i(disable_core_n_i), .mem_ready_i(mem_ready_i),
      .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
      .mem_wstrb_o(mem_wstrb_o), .overflow_o(overflow_o), .done_o(done_o)
`ifdef MYSTIC_PACKER_CHECKSUM_EN
      , .checksum_o(checksum_o)
`endif
   );

   typedef struct {
      logic [WA-1:0] waddr;
      logic [63:0]   data;
      logic [7:0]    strb;
   } wr_t;

   wr_t  exp_q[$];
   int   checks = 0, errors = 0;
   int   exp_done = 0, done_seen = 0, writes_seen = 0, extra = 0;
   logic exp_ovf;

   // Model: current open word as a lane array.
   logic [7:0]    m_lane [8];
   logic [7:0]    m_strb;
   logic [WA-1:0] m_word;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic void m_emit();
      wr_t w;
      w.waddr = m_word;
      w.strb  = m_strb;
      w.data  = '0;
      for (int k = 0; k < 8; k++)
         if (m_strb[k]) w.data[8*k +: 8] = m_lane[k];
      exp_q.push_back(w);
      m_strb = '0;
   endfunction

   function automatic void m_byte(input logic [7:0] b, input logic [ADDR_W-1:0] a);
      logic [WA-1:0] w;
      int            l;
      w = a[ADDR_W-1:3];
      l = int'(a[2:0]);
`ifdef MYSTIC_PACKER_CHECKSUM_EN
      m_sum = m_sum + {24'd0, b};
`endif
      if (m_strb != 8'd0 && w != m_word) begin
         m_emit();
         m_lane[l] = b; m_strb[l] = 1'b1; m_word = w;
      end else begin
         m_lane[l] = b; m_strb[l] = 1'b1; m_word = w;
         if (l == 7) m_emit();
      end
   endfunction

   function automatic void m_drain();
      if (m_strb != 8'd0) m_emit();
   endfunction

   // Monitor: scoreboard on accepted writes, stability while stalled, done count.
   initial begin
      wr_t         e;
      logic        pstall;
      logic [63:0] pdata;
      logic [31:0] pmeta;
      pstall = 1'b0; pdata = '0; pmeta = '0;
      forever begin
         @(negedge clk);
         if (rst_i) pstall = 1'b0;
         else begin
            if (pstall) begin
               chk("stable_data", mem_wdata_o, pdata);
               chk("stable_meta", 64'({mem_we_o, mem_wstrb_o, mem_waddr_o}), 64'(pmeta));
            end
            if (mem_we_o && mem_ready_i) begin
               writes_seen++;
               if (exp_q.size() == 0) extra++;
               else begin
                  e = exp_q.pop_front();
                  chk("sb_waddr", 64'(mem_waddr_o), 64'(e.waddr));
                  chk("sb_wdata", mem_wdata_o, e.data);
                  chk("sb_wstrb", 64'(mem_wstrb_o), 64'(e.strb));
               end
            end
            pstall = mem_we_o && !mem_ready_i;
            pdata  = mem_wdata_o;
            pmeta  = 32'({mem_we_o, mem_wstrb_o, mem_waddr_o});
            if (done_o) done_seen++;
         end
      end
   end

   // Random ready: stalls of at most 2 cycles, shorter than the byte spacing.
   initial begin
      int z;
      z = 0; rnd_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (z >= 2) rnd_ready = 1'b1;
         else        rnd_ready = ($urandom_range(0, 3) != 0);
         z = rnd_ready ? 0 : z + 1;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [7:0] b, input logic [ADDR_W-1:0] a, input bit mdl, input int gap);
      byte_i = b; byte_addr_i = a; byte_we_i = 1'b1;
      if (mdl) m_byte(b, a);
      tick();
      byte_we_i = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic start_load();
      disable_core_n_i = 1'b0;
      m_strb = '0; exp_ovf = 1'b0;
`ifdef MYSTIC_PACKER_CHECKSUM_EN
      m_sum = '0;
`endif
      tick();
      @(negedge clk);
      chk("ovf_clear", 64'(overflow_o), 64'd0);
`ifdef MYSTIC_PACKER_CHECKSUM_EN
      chk("sum_clear", 64'(checksum_o), 64'd0);
`endif
      tick();
   endtask

   task automatic raise_disable(input bit with_byte, input logic [7:0] b, input logic [ADDR_W-1:0] a);
      disable_core_n_i = 1'b1;
      if (with_byte) begin
         byte_i = b; byte_addr_i = a; byte_we_i = 1'b1;
         m_byte(b, a);
      end
      tick();
      byte_we_i = 1'b0;
      m_drain();
      exp_done++;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 60; i++) begin
         if (done_seen >= exp_done) break;
         @(negedge clk); #1;
      end
      chk("done_seen", 64'(done_seen), 64'(exp_done));
      chk("q_empty", 64'(exp_q.size()), 64'd0);
      chk("extra_writes", 64'(extra), 64'd0);
      chk("overflow", 64'(overflow_o), 64'(exp_ovf));
`ifdef MYSTIC_PACKER_CHECKSUM_EN
      chk("checksum", 64'(checksum_o), 64'(m_sum));
`endif
      repeat (3) tick();
      chk("done_once", 64'(done_seen), 64'(exp_done));
   endtask

   initial begin
      int ws, ds, n;
      logic [ADDR_W-1:0] a;
      rst_i = 1'b1; disable_core_n_i = 1'b1; byte_we_i = 1'b0; byte_i = '0; byte_addr_i = '0;
      man_ready = 1'b1; rnd_mode = 1'b0; exp_ovf = 1'b0; m_strb = '0; m_word = '0;
      for (int k = 0; k < 8; k++) m_lane[k] = '0;
`ifdef MYSTIC_PACKER_CHECKSUM_EN
      m_sum = '0;
`endif
      repeat (3) tick();
      rst_i = 1'b0;
      @(negedge clk);
      chk("rst_meta", 64'({mem_we_o, overflow_o, done_o, mem_wstrb_o, mem_waddr_o}), 64'd0);
      chk("rst_data", mem_wdata_o, 64'd0);
      tick();

      // Full word, lane 7 completes it.
      start_load();
      for (int i = 0; i < 7; i++) send(8'(i + 1), ADDR_W'(i), 1'b1, 3);
      send(8'h08, ADDR_W'(7), 1'b1, 0);
      @(negedge clk);
      chk("fw_we", 64'(mem_we_o), 64'd1);
      chk("fw_waddr", 64'(mem_waddr_o), 64'd0);
      chk("fw_data", mem_wdata_o, 64'h0807060504030201);
      chk("fw_strb", 64'(mem_wstrb_o), 64'hFF);
      tick();
      @(negedge clk);
      chk("fw_we_low", 64'(mem_we_o), 64'd0);
      tick();
      raise_disable(1'b0, 8'h00, '0);
      wait_done();

      // Word change, then end of load with a partial word.
      start_load();
      send(8'hAB, ADDR_W'('h10), 1'b1, 3);
      send(8'hCD, ADDR_W'('h11), 1'b1, 3);
      send(8'h12, ADDR_W'('h20), 1'b1, 0);
      @(negedge clk);
      chk("wc_we", 64'(mem_we_o), 64'd1);
      chk("wc_waddr", 64'(mem_waddr_o), 64'd2);
      chk("wc_strb", 64'(mem_wstrb_o), 64'h03);
      chk("wc_lo", 64'(mem_wdata_o[15:0]), 64'hCDAB);
      repeat (4) tick();
      send(8'h34, ADDR_W'('h2B), 1'b1, 4);
      raise_disable(1'b0, 8'h00, '0);
      @(negedge clk);
      chk("dr_we0", 64'(mem_we_o), 64'd0);
      tick();
      @(negedge clk);
      chk("dr_we1", 64'(mem_we_o), 64'd1);
      chk("dr_waddr", 64'(mem_waddr_o), 64'd5);
      chk("dr_strb", 64'(mem_wstrb_o), 64'h08);
      chk("dr_data", mem_wdata_o, 64'h0000_0000_3400_0000);
      wait_done();

      // Backpressure: lane-7 byte of the second word is dropped.
      start_load();
      man_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(8'(8'h10 + i), ADDR_W'('h40 + i), 1'b1, 3);
      for (int i = 0; i < 7; i++) send(8'(8'h20 + i), ADDR_W'('h48 + i), 1'b1, 3);
      @(negedge clk);
      chk("bp_ovf0", 64'(overflow_o), 64'd0);
      tick();
      send(8'h27, ADDR_W'('h4F), 1'b0, 0);
      exp_ovf = 1'b1;
      @(negedge clk);
      chk("bp_ovf1", 64'(overflow_o), 64'd1);
      chk("bp_we", 64'(mem_we_o), 64'd1);
      chk("bp_waddr", 64'(mem_waddr_o), 64'd8);
      chk("bp_data", mem_wdata_o, 64'h1716151413121110);
      tick();
      repeat (4) tick();
      man_ready = 1'b1;
      tick();
      raise_disable(1'b0, 8'h00, '0);
      wait_done();

      // Byte while idle is ignored; empty load finishes one cycle after drain entry.
      send(8'hEE, ADDR_W'('h30), 1'b0, 2);
      start_load();
      raise_disable(1'b0, 8'h00, '0);
      @(negedge clk);
      chk("empty_done0", 64'(done_o), 64'd0);
      tick();
      @(negedge clk);
      chk("empty_done1", 64'(done_o), 64'd1);
      wait_done();

      // Reset mid-load with a pending word and a partial accumulator.
      start_load();
      man_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(8'(8'h50 + i), ADDR_W'('h80 + i), 1'b1, 3);
      for (int i = 0; i < 5; i++) send(8'(8'h60 + i), ADDR_W'('h88 + i), 1'b1, 3);
      disable_core_n_i = 1'b1;
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      exp_q.delete();
      m_strb = '0;
      @(negedge clk);
      chk("rr_meta", 64'({mem_we_o, overflow_o, done_o, mem_wstrb_o, mem_waddr_o}), 64'd0);
      chk("rr_data", mem_wdata_o, 64'd0);
      tick();
      man_ready = 1'b1;
      ws = writes_seen; ds = done_seen;
      repeat (20) tick();
      chk("rr_nowrite", 64'(writes_seen), 64'(ws));
      chk("rr_nodone", 64'(done_seen), 64'(ds));

      // Random loads with random short memory stalls.
      rnd_mode = 1'b1;
      for (int ld = 0; ld < 6; ld++) begin
         start_load();
         a = ADDR_W'($urandom_range(0, 511));
         n = $urandom_range(12, 40);
         for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3, 4, 5: a = a + 1'b1;
               6, 7:             a = {a[ADDR_W-1:3], 3'($urandom_range(0, 7))};
               default:          a = ADDR_W'($urandom_range(0, 511));
            endcase
            send(8'($urandom_range(0, 255)), a, 1'b1, $urandom_range(4, 8));
         end
         if ($urandom_range(0, 1) == 1)
            raise_disable(1'b1, 8'($urandom_range(0, 255)), a + 1'b1);
         else
            raise_disable(1'b0, 8'h00, '0);
         wait_done();
      end
      rnd_mode = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
